// File: rtl/xor_cipher_pkg.sv
// Shared definitions for the XOR cipher sequencer: FSM state encodings, the
// default key-load command byte and the key index width helper.
package xor_cipher_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_TAKE    = 3'd1;
  localparam logic [2:0] ST_KEY     = 3'd2;
  localparam logic [2:0] ST_XOR     = 3'd3;
  localparam logic [2:0] ST_WAIT_TX = 3'd4;
  localparam logic [2:0] ST_SEND    = 3'd5;

  localparam logic [7:0] KEY_CMD_DEFAULT = 8'h1B;

  // A single-byte key still needs a one-bit index.
  function automatic int idx_width(input int key_len);
    return (key_len > 1) ? $clog2(key_len) : 1;
  endfunction

endpackage

// File: rtl/xor_key_file.sv
// Key store: KEY_LEN registers of W bits, one synchronous write port and one
// combinational read port, cleared asynchronously on reset.
module xor_key_file
  import xor_cipher_pkg::*;
#(
  parameter int W       = 8,
  parameter int KEY_LEN = 4,
  parameter int IDX_W   = idx_width(KEY_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [W-1:0]     wdata,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] key_q [KEY_LEN];
  logic [W-1:0] key_d [KEY_LEN];

  always_comb begin
    key_d = key_q;
    if (we) key_d[wr_idx] = wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < KEY_LEN; i++) key_q[i] <= '0;
    end else begin
      key_q <= key_d;
    end
  end

  assign rdata = key_q[rd_idx];

endmodule

// File: rtl/xor_cipher_seq.sv
// Sequencer between the RX and TX UART flag buffers: takes each received byte,
// loads the rolling key on command, otherwise XORs and hands it to the transmitter.
module xor_cipher_seq
  import xor_cipher_pkg::*;
#(
  parameter int             W       = 8,
  parameter int             KEY_LEN = 4,
  parameter logic [W-1:0]   KEY_CMD = W'(KEY_CMD_DEFAULT),
  parameter int             CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_flag,
  input  logic [W-1:0]     rx_data,
  output logic             rx_clr,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [W-1:0]     tx_data,
  input  logic             enable,
  output logic             key_valid,
  output logic [CNT_W-1:0] byte_cnt
);

  localparam int IDX_W = idx_width(KEY_LEN);
  localparam int LC_W  = $clog2(KEY_LEN + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KEY_LEN - 1);
  localparam logic [LC_W-1:0]  LC_FULL  = LC_W'(KEY_LEN);
  localparam logic [LC_W-1:0]  LC_ONE   = LC_W'(1);

  logic [2:0]       state_q, state_d;
  logic [W-1:0]     data_q, data_d;
  logic [W-1:0]     tx_data_q, tx_data_d;
  logic             key_valid_q, key_valid_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [LC_W-1:0]  load_cnt_q, load_cnt_d;
  logic             key_we;
  logic [W-1:0]     key_rdata;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
  endfunction

  xor_key_file #(
    .W      (W),
    .KEY_LEN(KEY_LEN),
    .IDX_W  (IDX_W)
  ) u_key_file (
    .clk   (clk),
    .reset (reset),
    .we    (key_we),
    .wr_idx(wr_idx_q),
    .wdata (data_q),
    .rd_idx(rd_idx_q),
    .rdata (key_rdata)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    tx_data_d   = tx_data_q;
    key_valid_d = key_valid_q;
    byte_cnt_d  = byte_cnt_q;
    rd_idx_d    = rd_idx_q;
    wr_idx_d    = wr_idx_q;
    load_cnt_d  = load_cnt_q;
    key_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_flag) begin
          data_d  = rx_data;
          state_d = ST_TAKE;
        end
      end
      ST_TAKE: begin
        // Pending key bytes take precedence, so a command value is a legal key byte.
        if (load_cnt_q != '0) begin
          state_d = ST_KEY;
        end else if (data_q == KEY_CMD) begin
          load_cnt_d  = LC_FULL;
          wr_idx_d    = '0;
          key_valid_d = 1'b0;
          rd_idx_d    = '0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_XOR;
        end
      end
      ST_KEY: begin
        key_we     = 1'b1;
        wr_idx_d   = next_idx(wr_idx_q);
        load_cnt_d = load_cnt_q - LC_ONE;
        if (load_cnt_q == LC_ONE) begin
          key_valid_d = 1'b1;
          rd_idx_d    = '0;
        end
        state_d = ST_IDLE;
      end
      ST_XOR: begin
        // The key phase only moves when the key is applied; passthrough keeps it parked.
        if (enable && key_valid_q) begin
          tx_data_d = data_q ^ key_rdata;
          rd_idx_d  = next_idx(rd_idx_q);
        end else begin
          tx_data_d = data_q;
        end
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (!tx_busy) state_d = ST_SEND;
      end
      ST_SEND: begin
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      tx_data_q   <= '0;
      key_valid_q <= 1'b0;
      byte_cnt_q  <= '0;
      rd_idx_q    <= '0;
      wr_idx_q    <= '0;
      load_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      tx_data_q   <= tx_data_d;
      key_valid_q <= key_valid_d;
      byte_cnt_q  <= byte_cnt_d;
      rd_idx_q    <= rd_idx_d;
      wr_idx_q    <= wr_idx_d;
      load_cnt_q  <= load_cnt_d;
    end
  end

  assign rx_clr    = (state_q == ST_TAKE);
  assign tx_start  = (state_q == ST_SEND);
  assign tx_data   = tx_data_q;
  assign key_valid = key_valid_q;
  assign byte_cnt  = byte_cnt_q;

endmodule
